// File: rtl/serial_word_feeder_if.sv
// Word-in / bit-out bundle for the serial feeder: parallel valid/ready input side
// plus the registered serial output, framing strobes and busy flag.
interface serial_word_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             sof;
  logic             eof;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, x, x_valid, sof, eof, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, x, x_valid, sof, eof, busy
  );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder, LSB first, sof/eof framed; bit k of a word accepted at edge N shows from edge N+k.
// in_ready only in IDLE, last bit (GAP=0) or last gap cycle; in_data is ignored otherwise.
module serial_word_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic                t_clock,
  input logic                r,
  serial_word_feeder_if.slave sif
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_PEN  = CW'(WIDTH - 2);
  localparam logic [3:0]      GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] sreg;
  logic             x_valid_q;
  logic             sof_q;
  logic             eof_q;
  logic             ready;
  logic             xfer;

  // Ready is gated by reset so no word can be taken while r is low.
  assign ready = r & ((state == ST_IDLE) |
                      ((state == ST_SHIFT) & (cnt == CNT_LAST) & (GAP == 0)) |
                      ((state == ST_GAP) & (gap_cnt == GAP_LAST)));
  assign xfer  = sif.in_valid & ready;

  // sreg[0] is the serial bit itself; sreg is zeroed outside SHIFT so x idles low.
  always_ff @(posedge t_clock or negedge r) begin
    if (!r) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      sreg      <= '0;
      x_valid_q <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else if (xfer) begin
      state     <= ST_SHIFT;
      cnt       <= '0;
      gap_cnt   <= '0;
      sreg      <= sif.in_data;
      x_valid_q <= 1'b1;
      sof_q     <= 1'b1;
      eof_q     <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cnt != CNT_LAST) begin
            cnt   <= cnt + 1'b1;
            sreg  <= {1'b0, sreg[WIDTH-1:1]};
            sof_q <= 1'b0;
            eof_q <= (cnt == CNT_PEN);
          end else begin
            sreg      <= '0;
            x_valid_q <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            gap_cnt   <= '0;
            state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sif.in_ready = ready;
  assign sif.x        = sreg[0];
  assign sif.x_valid  = x_valid_q;
  assign sif.sof      = sof_q;
  assign sif.eof      = eof_q;
  assign sif.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: three configurations (8/1, 8/0, 4/2) with per-bit
// scoreboards on the 8-bit instances and directed framing/timing checks.
module tb_serial_word_feeder;

  logic t_clock;
  logic r;

  serial_word_feeder_if #(.WIDTH(8)) ifa ();
  serial_word_feeder_if #(.WIDTH(8)) ifb ();
  serial_word_feeder_if #(.WIDTH(4)) ifc ();

  serial_word_feeder #(.WIDTH(8), .GAP(1)) u_dut_a (.t_clock(t_clock), .r(r), .sif(ifa));
  serial_word_feeder #(.WIDTH(8), .GAP(0)) u_dut_b (.t_clock(t_clock), .r(r), .sif(ifb));
  serial_word_feeder #(.WIDTH(4), .GAP(2)) u_dut_c (.t_clock(t_clock), .r(r), .sif(ifc));

  int checks = 0;
  int errors = 0;
  int hs_a   = 0;
  int hs_b   = 0;
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  logic [7:0] tbl[3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    t_clock = 1'b0;
    forever #5 t_clock = ~t_clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboards: expected {sof,eof,x} per bit pushed at the accepting edge.
  always @(negedge t_clock) begin
    if (!r) qa.delete();
    else begin
      if (ifa.x_valid) begin
        if (qa.size() == 0) check("a_extra_bit", 32'(ifa.x_valid), 32'd0);
        else check("a_bit", 32'({ifa.sof, ifa.eof, ifa.x}), 32'(qa.pop_front()));
      end else check("a_idle_out", 32'({ifa.sof, ifa.eof, ifa.x}), 32'd0);
      if (ifa.in_valid && ifa.in_ready) begin
        for (int i = 0; i < 8; i++) qa.push_back({i == 0, i == 7, ifa.in_data[i]});
        hs_a++;
      end
    end
  end

  always @(negedge t_clock) begin
    if (!r) qb.delete();
    else begin
      if (ifb.x_valid) begin
        if (qb.size() == 0) check("b_extra_bit", 32'(ifb.x_valid), 32'd0);
        else check("b_bit", 32'({ifb.sof, ifb.eof, ifb.x}), 32'(qb.pop_front()));
      end else check("b_idle_out", 32'({ifb.sof, ifb.eof, ifb.x}), 32'd0);
      if (ifb.in_valid && ifb.in_ready) begin
        for (int i = 0; i < 8; i++) qb.push_back({i == 0, i == 7, ifb.in_data[i]});
        hs_b++;
      end
    end
  end

  task automatic accept_a(input logic [7:0] d, input bit drop);
    bit done = 1'b0;
    ifa.in_data  = d;
    ifa.in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge t_clock);
      if (ifa.in_ready) begin
        @(posedge t_clock); #1;
        done = 1'b1;
      end
    end
    if (!done) check("a_accept_timeout", 32'(ifa.in_ready), 32'd1);
    if (drop) ifa.in_valid = 1'b0;
  endtask

  task automatic accept_b(input logic [7:0] d, input bit drop);
    bit done = 1'b0;
    ifb.in_data  = d;
    ifb.in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge t_clock);
      if (ifb.in_ready) begin
        @(posedge t_clock); #1;
        done = 1'b1;
      end
    end
    if (!done) check("b_accept_timeout", 32'(ifb.in_ready), 32'd1);
    if (drop) ifb.in_valid = 1'b0;
  endtask

  task automatic accept_c(input logic [3:0] d, input bit drop);
    bit done = 1'b0;
    ifc.in_data  = d;
    ifc.in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge t_clock);
      if (ifc.in_ready) begin
        @(posedge t_clock); #1;
        done = 1'b1;
      end
    end
    if (!done) check("c_accept_timeout", 32'(ifc.in_ready), 32'd1);
    if (drop) ifc.in_valid = 1'b0;
  endtask

  initial begin
    int hs0;
    r = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 8'hFF;
    ifb.in_valid = 1'b1; ifb.in_data = 8'hFF;
    ifc.in_valid = 1'b1; ifc.in_data = 4'hF;

    // Reset held with in_valid asserted: everything quiet, nothing taken.
    repeat (3) @(posedge t_clock);
    #1;
    check("rst_a_outs", 32'({ifa.x, ifa.x_valid, ifa.sof, ifa.eof, ifa.busy, ifa.in_ready}), 32'd0);
    check("rst_b_rdy", 32'(ifb.in_ready), 32'd0);
    check("rst_c_rdy", 32'(ifc.in_ready), 32'd0);
    r = 1'b1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge t_clock);
    check("rel_a_rdy", 32'(ifa.in_ready), 32'd1);
    check("rel_a_busy", 32'(ifa.busy), 32'd0);
    check("rst_no_xfer", 32'(hs_a), 32'd0);

    // Single word, one gap cycle.
    @(posedge t_clock); #1;
    accept_a(8'hB4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge t_clock);
      check("t2_vld", 32'(ifa.x_valid), 32'd1);
    end
    @(negedge t_clock);
    check("t2_gap_vld", 32'(ifa.x_valid), 32'd0);
    check("t2_gap_rdy", 32'(ifa.in_ready), 32'd1);
    check("t2_gap_busy", 32'(ifa.busy), 32'd1);
    @(negedge t_clock);
    check("t2_idle_busy", 32'(ifa.busy), 32'd0);

    // Back-to-back without gap.
    @(posedge t_clock); #1;
    accept_b(8'h01, 1'b0);
    ifb.in_data = 8'h80;
    for (int k = 0; k < 16; k++) begin
      @(negedge t_clock);
      check("t3_vld", 32'(ifb.x_valid), 32'd1);
      if (k == 7) check("t3_last_rdy", 32'(ifb.in_ready), 32'd1);
      @(posedge t_clock); #1;
      if (k == 7) ifb.in_valid = 1'b0;
    end
    @(negedge t_clock);
    check("t3_end_vld", 32'(ifb.x_valid), 32'd0);
    check("t3_end_busy", 32'(ifb.busy), 32'd0);
    check("t3_hs", 32'(hs_b), 32'd2);

    // Backpressure: in_data churns during SHIFT, only the accepting-edge value counts.
    @(posedge t_clock); #1;
    hs0 = hs_a;
    accept_a(8'h5A, 1'b0);
    for (int k = 0; k < 17; k++) begin
      @(negedge t_clock);
      check("t4_busy", 32'(ifa.busy), 32'd1);
      if (k == 8) check("t4_gap_vld", 32'(ifa.x_valid), 32'd0);
      @(posedge t_clock); #1;
      if (k < 8) ifa.in_data = tbl[k % 3];
      else if (k == 8) ifa.in_valid = 1'b0;
    end
    check("t4_hs", 32'(hs_a - hs0), 32'd2);
    repeat (3) @(posedge t_clock);
    #1;

    // Reset during bit 3: outputs drop at once, word abandoned.
    accept_a(8'h5A, 1'b1);
    repeat (3) @(posedge t_clock);
    #1;
    r = 1'b0;
    #1;
    check("t5_rst_outs", 32'({ifa.x, ifa.x_valid, ifa.sof, ifa.eof, ifa.busy, ifa.in_ready}), 32'd0);
    @(negedge t_clock);
    check("t5_no_eof", 32'(ifa.eof), 32'd0);
    @(negedge t_clock);
    check("t5_no_eof2", 32'(ifa.eof), 32'd0);
    @(posedge t_clock); #1;
    r = 1'b1;
    hs0 = hs_a;
    accept_a(8'h0F, 1'b1);
    @(negedge t_clock);
    check("t5_sof", 32'(ifa.sof), 32'd1);
    repeat (10) @(posedge t_clock);
    check("t5_hs", 32'(hs_a - hs0), 32'd1);

    // Gap timing, WIDTH=4 GAP=2, continuous 4'hF.
    @(posedge t_clock); #1;
    accept_c(4'hF, 1'b0);
    for (int k = 0; k < 18; k++) begin
      @(negedge t_clock);
      check("t6_vld", 32'(ifc.x_valid), 32'((k % 6) < 4));
      check("t6_x", 32'(ifc.x), 32'((k % 6) < 4));
      check("t6_rdy", 32'(ifc.in_ready), 32'((k % 6) == 5));
    end
    @(posedge t_clock); #1;
    ifc.in_valid = 1'b0;
    repeat (8) @(negedge t_clock);
    check("t6_idle_busy", 32'(ifc.busy), 32'd0);

    check("a_q_drain", 32'(qa.size()), 32'd0);
    check("b_q_drain", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
